// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: address/byte-enable types and the lane-merge helper.
// Used by both the array write path and the optional same-word write-to-read forwarding path.
package mem_responder_pkg;

  localparam int MEM_WORD_BYTES = 4;

  typedef logic [3:0]  mem_be_t;
  typedef logic [31:0] mem_addr_t;
  typedef logic [31:0] mem_word_t;

  function automatic mem_word_t mem_be_merge(input mem_word_t old_word,
                                             input mem_word_t new_word,
                                             input mem_be_t   be);
    mem_word_t merged;
    merged = old_word;
    for (int n = 0; n < MEM_WORD_BYTES; n++) begin
      if (be[n]) merged[8*n +: 8] = new_word[8*n +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response shift pipeline, LATENCY stages deep: one request per cycle in, same order out.
// No backpressure; the data lane holds zero in any stage whose valid bit is clear.
module mem_rd_pipe
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      in_vld,
  input  mem_word_t in_dat,
  output logic      out_vld,
  output mem_word_t out_dat
);

  logic [LATENCY-1:0] vld_q;
  mem_word_t          dat_q [LATENCY];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      dat_q[0] <= in_vld ? in_dat : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Word memory for the core datapath: reads return after RD_LATENCY cycles, fully pipelined, no backpressure.
// Define MEM_WR_FORWARD_EN to return the merged post-write word on a same-cycle read/write to one word.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int        DEPTH      = 1024,
  parameter int        RD_LATENCY = 1,
  parameter mem_addr_t BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_rd_req_i,
  input  logic [31:0] mem_rd_addr_i,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_rd_valid_o,
  input  logic        mem_wr_enable_i,
  input  logic [31:0] mem_wr_addr_i,
  input  logic [31:0] mem_wr_data_i,
  input  logic [3:0]  mem_wr_be_i,
  output logic        mem_err_o
);

  localparam int        IDX_W = $clog2(DEPTH);
  localparam mem_addr_t SPAN  = 32'(DEPTH * MEM_WORD_BYTES);

  mem_word_t        mem_q [DEPTH];
  mem_addr_t        rd_off, wr_off;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             rd_bad, wr_bad;
  logic             err_q;
  mem_word_t        rd_word;

  // Offsets wrap modulo DEPTH; out-of-range and misaligned accesses still execute at the wrapped index.
  assign rd_off = mem_rd_addr_i - BASE_ADDR;
  assign wr_off = mem_wr_addr_i - BASE_ADDR;
  assign rd_idx = rd_off[IDX_W+1:2];
  assign wr_idx = wr_off[IDX_W+1:2];
  assign rd_bad = (mem_rd_addr_i[1:0] != 2'b00) || (rd_off >= SPAN);
  assign wr_bad = (mem_wr_addr_i[1:0] != 2'b00) || (wr_off >= SPAN);

  always_comb begin
    rd_word = mem_q[rd_idx];
`ifdef MEM_WR_FORWARD_EN
    if (mem_wr_enable_i && (wr_idx == rd_idx))
      rd_word = mem_be_merge(rd_word, mem_wr_data_i, mem_wr_be_i);
`endif
  end

  // The array carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (mem_wr_enable_i)
      mem_q[wr_idx] <= mem_be_merge(mem_q[wr_idx], mem_wr_data_i, mem_wr_be_i);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) err_q <= 1'b0;
    else          err_q <= (mem_rd_req_i && rd_bad) || (mem_wr_enable_i && wr_bad);
  end

  assign mem_err_o = err_q;

  generate
    if (RD_LATENCY == 0) begin : g_comb_rd
      assign mem_rd_valid_o = mem_rd_req_i;
      assign mem_rd_data_o  = mem_rd_req_i ? rd_word : '0;
    end else begin : g_pipe_rd
      mem_rd_pipe #(.LATENCY(RD_LATENCY)) u_rd_pipe (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .in_vld  (mem_rd_req_i),
        .in_dat  (rd_word),
        .out_vld (mem_rd_valid_o),
        .out_dat (mem_rd_data_o)
      );
    end
  endgenerate

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against a schedule-based reference model.
module tb_mem_responder;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          NSCH  = 8192;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        mem_rd_req_i = 1'b0;
  logic [31:0] mem_rd_addr_i = '0;
  logic [31:0] mem_rd_data_o;
  logic        mem_rd_valid_o;
  logic        mem_wr_enable_i = 1'b0;
  logic [31:0] mem_wr_addr_i = '0;
  logic [31:0] mem_wr_data_i = '0;
  logic [3:0]  mem_wr_be_i = '0;
  logic        mem_err_o;

  mem_responder #(.DEPTH(DEPTH), .RD_LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .mem_rd_req_i    (mem_rd_req_i),
    .mem_rd_addr_i   (mem_rd_addr_i),
    .mem_rd_data_o   (mem_rd_data_o),
    .mem_rd_valid_o  (mem_rd_valid_o),
    .mem_wr_enable_i (mem_wr_enable_i),
    .mem_wr_addr_i   (mem_wr_addr_i),
    .mem_wr_data_i   (mem_wr_data_i),
    .mem_wr_be_i     (mem_wr_be_i),
    .mem_err_o       (mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: word array plus per-edge schedule of what the outputs must show after that edge.
  logic [31:0] model_mem [DEPTH];
  bit          sched_vld [NSCH];
  logic [31:0] sched_dat [NSCH];
  bit          sched_err [NSCH];
  int          edge_n = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] got_q [$];
  int          got_e [$];

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) % DEPTH);
  endfunction

  function automatic bit bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = BASE + 32'($urandom_range(0, 63)) * 4;
    case ($urandom_range(0, 7))
      0: a = a + 32'($urandom_range(1, 3));
      1: a = a + 32'h1000 * 32'($urandom_range(1, 3));
      default: ;
    endcase
    return a;
  endfunction

  task automatic check_outputs();
    vectors += 3;
    assert (mem_rd_valid_o === sched_vld[edge_n]) else begin
      miscompares++;
      $error("FAIL rd_valid edge %0d: got %b want %b", edge_n, mem_rd_valid_o, sched_vld[edge_n]);
    end
    assert (mem_rd_data_o === (sched_vld[edge_n] ? sched_dat[edge_n] : 32'h0)) else begin
      miscompares++;
      $error("FAIL rd_data edge %0d: got %h want %h", edge_n, mem_rd_data_o,
             sched_vld[edge_n] ? sched_dat[edge_n] : 32'h0);
    end
    assert (mem_err_o === sched_err[edge_n]) else begin
      miscompares++;
      $error("FAIL err edge %0d: got %b want %b", edge_n, mem_err_o, sched_err[edge_n]);
    end
    if (mem_rd_valid_o === 1'b1) begin
      got_q.push_back(mem_rd_data_o);
      got_e.push_back(edge_n);
    end
  endtask

  task automatic step(input bit rq, input logic [31:0] ra, input bit we,
                      input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
    int k, ri, wi;
    logic [31:0] rv;
    mem_rd_req_i = rq; mem_rd_addr_i = ra;
    mem_wr_enable_i = we; mem_wr_addr_i = wa; mem_wr_data_i = wd; mem_wr_be_i = be;
    k  = edge_n + 1;
    ri = widx(ra);
    wi = widx(wa);
    if (rq) begin
      rv = model_mem[ri];
`ifdef MEM_WR_FORWARD_EN
      if (we && wi == ri)
        for (int n = 0; n < 4; n++) if (be[n]) rv[8*n +: 8] = wd[8*n +: 8];
`endif
      sched_vld[k+LAT-1] = 1'b1;
      sched_dat[k+LAT-1] = rv;
    end
    if ((rq && bad(ra)) || (we && bad(wa))) sched_err[k] = 1'b1;
    if (we)
      for (int n = 0; n < 4; n++) if (be[n]) model_mem[wi][8*n +: 8] = wd[8*n +: 8];
    @(posedge clk_i);
    edge_n++;
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic check_zero(input string tag);
    vectors += 3;
    assert (mem_rd_valid_o === 1'b0) else begin
      miscompares++; $error("FAIL %s rd_valid: got %b want 0", tag, mem_rd_valid_o);
    end
    assert (mem_rd_data_o === 32'h0) else begin
      miscompares++; $error("FAIL %s rd_data: got %h want 0", tag, mem_rd_data_o);
    end
    assert (mem_err_o === 1'b0) else begin
      miscompares++; $error("FAIL %s err: got %b want 0", tag, mem_err_o);
    end
  endtask

  task automatic do_reset();
    mem_rd_req_i = 1'b0;
    mem_wr_enable_i = 1'b0;
    reset_i = 1'b0;
    #1;
    check_zero("reset_assert");
    for (int i = 0; i < NSCH; i++) begin
      sched_vld[i] = 1'b0; sched_dat[i] = '0; sched_err[i] = 1'b0;
    end
    repeat (2) begin
      @(posedge clk_i);
      edge_n++;
    end
    @(negedge clk_i);
    check_zero("reset_hold");
    reset_i = 1'b1;
  endtask

  task automatic expect_got(input string tag, input logic [31:0] exp);
    logic [31:0] g;
    g = 32'hxxxx_xxxx;
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      void'(got_e.pop_front());
    end
    vectors++;
    assert (g === exp) else begin
      miscompares++; $error("FAIL %s: got %h want %h", tag, g, exp);
    end
  endtask

  task automatic clear_got();
    got_q.delete();
    got_e.delete();
  endtask

  initial begin
    int k0, e;
    logic [31:0] w;

    do_reset();

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      step(1'b0, 32'h0, 1'b1, BASE + 32'(i * 4), w, 4'hF);
    end

    // Write then read back
    clear_got();
    step(1'b0, 32'h0, 1'b1, BASE + 32'h20, 32'hDEADBEEF, 4'hF);
    step(1'b1, BASE + 32'h20, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(LAT);
    expect_got("wr_rd", 32'hDEADBEEF);

    // Byte-lane merge
    clear_got();
    step(1'b0, 32'h0, 1'b1, BASE + 32'h20, 32'h11223344, 4'b0101);
    step(1'b1, BASE + 32'h20, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(LAT);
    expect_got("byte_en", 32'hDE22BE44);

    // Zero byte enable leaves the word alone
    clear_got();
    step(1'b0, 32'h0, 1'b1, BASE + 32'h20, 32'h0BAD0BAD, 4'b0000);
    step(1'b1, BASE + 32'h20, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(LAT);
    expect_got("be_zero", 32'hDE22BE44);

    // Same-cycle read and write to one word
    clear_got();
    step(1'b0, 32'h0, 1'b1, BASE + 32'h40, 32'hAAAAAAAA, 4'hF);
    step(1'b1, BASE + 32'h40, 1'b1, BASE + 32'h40, 32'h55555555, 4'hF);
    step(1'b1, BASE + 32'h40, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(LAT);
`ifdef MEM_WR_FORWARD_EN
    expect_got("same_cycle", 32'h55555555);
`else
    expect_got("same_cycle", 32'hAAAAAAAA);
`endif
    expect_got("after_same_cycle", 32'h55555555);

    // Wrap and error pulse
    clear_got();
    step(1'b1, BASE + 32'h1004, 1'b0, 32'h0, 32'h0, 4'h0);
    vectors++;
    assert (mem_err_o === 1'b1) else begin
      miscompares++; $error("FAIL wrap_err: got %b want 1", mem_err_o);
    end
    step(1'b1, BASE + 32'h22, 1'b0, 32'h0, 32'h0, 4'h0);
    vectors++;
    assert (mem_err_o === 1'b1) else begin
      miscompares++; $error("FAIL misalign_err: got %b want 1", mem_err_o);
    end
    idle(1);
    vectors++;
    assert (mem_err_o === 1'b0) else begin
      miscompares++; $error("FAIL err_one_cycle: got %b want 0", mem_err_o);
    end
    idle(LAT);
    expect_got("wrap_data", model_mem[1]);
    expect_got("misalign_data", model_mem[8]);

    // Back-to-back reads
    clear_got();
    k0 = edge_n + 1;
    for (int i = 0; i < 4; i++) step(1'b1, BASE + 32'(i * 4), 1'b0, 32'h0, 32'h0, 4'h0);
    idle(LAT + 1);
    for (int i = 0; i < 4; i++) begin
      e = (got_e.size() > 0) ? got_e[0] : -1;
      vectors++;
      assert (e == k0 + LAT - 1 + i) else begin
        miscompares++; $error("FAIL b2b_edge%0d: got %0d want %0d", i, e, k0 + LAT - 1 + i);
      end
      expect_got("b2b_data", model_mem[i]);
    end

    // Reset while a read is in flight
    clear_got();
    step(1'b1, BASE + 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
    do_reset();
    idle(LAT + 2);
    vectors++;
    assert (got_q.size() == 0) else begin
      miscompares++; $error("FAIL reset_drop: got %0d responses want 0", got_q.size());
    end
    step(1'b1, BASE + 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(LAT);
    expect_got("post_reset", model_mem[4]);

    // Randomized traffic against the schedule model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, wa;
      ra = rnd_addr();
      wa = ($urandom_range(0, 3) == 0) ? ra : rnd_addr();
      step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom));
    end
    idle(LAT + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
